// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data width, access size
// encodings, FSM state enumeration and small decode helpers.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    // Reserved size behaves exactly like a word access.
    function automatic logic is_word(input size_t sz);
        return (sz == SZ_WORD) || (sz == SZ_RSVD);
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) || (is_word(sz) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and RAM port bundle of the load/store unit.
// slave = the unit itself, master = requester plus RAM side.
interface load_store_unit_if import lsu_pkg::*; #(
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        output req_ready, resp_valid, resp_rdata, resp_fault, ram_rw, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_fault, ram_rw, ram_addr, ram_din
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: extracts and extends loaded bytes/halfwords and
// merges store data into a previously read word. Purely combinational.
// Misaligned low address bits are ignored here (forced to lane alignment).
module lsu_lane_align import lsu_pkg::*; (
    input  size_t             size,
    input  logic              is_unsigned,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane, extend it, and build the merged store word.
    always_comb begin
        lane_b     = rd_word[{addr_lo, 3'b000} +: 8];
        lane_h     = rd_word[{addr_lo[1], 4'b0000} +: 16];
        load_data  = rd_word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{~is_unsigned & lane_b[7]}}, lane_b};
                store_word = old_word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{~is_unsigned & lane_h[15]}}, lane_h};
                store_word = old_word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = rd_word;
                store_word = wdata;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a single-request master and a synchronous RAM.
// Sub-word stores are read-modify-write (RD, CAP, WR); word stores go
// straight to WR. Optional misaligned-access trapping: MISALIGN_TRAP_EN.
module load_store_unit import lsu_pkg::*; #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_unit_if.slave        bus
);
    state_t            state, state_d;
    logic [ADDR_W+1:0] addr_q;
    size_t             size_q;
    logic              we_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fault_q;
    logic              accept;
    logic              trap;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    assign accept = (state == IDLE) && bus.req_valid;

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(size_t'(bus.req_size), bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign bus.ram_addr = addr_q[ADDR_W+1:2];

    lsu_lane_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .rd_word     (bus.ram_dout),
        .old_word    (word_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state sequencing through the RAM access phases.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (trap)                                           state_d = RESP;
                else if (bus.req_we && is_word(size_t'(bus.req_size))) state_d = WR;
                else                                                state_d = RD;
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture at acceptance and RAM word capture in CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                size_q  <= size_t'(bus.req_size);
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                wdata_q <= bus.req_wdata;
                fault_q <= trap;
                rdata_q <= '0;
            end
            if (state == CAP) begin
                word_q <= bus.ram_dout;
                if (!we_q) rdata_q <= load_data;
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.req_ready  = (state == IDLE) && !rst;
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = (state == RESP) ? rdata_q : '0;
        bus.resp_fault = (state == RESP) && fault_q;
        bus.ram_rw     = (state != WR);
        bus.ram_din    = (state == WR) ? store_word : '0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural RAM, a memory-level reference model
// checked every cycle, and directed requests with literal expectations.
// Honours MISALIGN_TRAP_EN the same way as the design build.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W = 16;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous RAM: write when ram_rw=0, else registered read.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int unsigned wr_cnt = 0;
    always @(posedge clk) begin
        if (bus.ram_rw === 1'b0) begin
            mem[bus.ram_addr] <= bus.ram_din;
            wr_cnt <= wr_cnt + 1;
        end else begin
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0]  model_mem [int unsigned];
    bit           busy = 1'b0;
    int unsigned  cyc, lat;
    bit           e_wr, e_rd;
    int unsigned  e_waddr;
    logic [31:0]  e_din, e_rdata;
    logic         e_fault;
    int unsigned  acc_cnt = 0, resp_cnt = 0, pulse_cnt = 0;
    logic [31:0]  last_rdata;
    logic         last_fault;
    int unsigned  last_lat;

    // Work out the whole transaction from the accepted request.
    task automatic model_accept();
        logic [ADDR_W+1:0] a;
        int unsigned nb, lo, off;
        logic [31:0] w, v, m;
        a       = bus.req_addr;
        nb      = (bus.req_size == 2'b00) ? 1 : (bus.req_size == 2'b01) ? 2 : 4;
        lo      = int'(a[1:0]);
        off     = lo - (lo % nb);
        e_fault = TRAP && (off != lo);
        e_waddr = int'(a[ADDR_W+1:2]);
        w       = model_mem.exists(e_waddr) ? model_mem[e_waddr] : 32'h0;
        e_rdata = 32'h0;
        e_din   = 32'h0;
        if (e_fault) begin
            lat = 1; e_wr = 0; e_rd = 0;
        end else if (bus.req_we) begin
            e_wr  = 1;
            e_rd  = (nb != 4);
            lat   = (nb == 4) ? 2 : 4;
            e_din = w;
            for (int b = 0; b < int'(nb); b++)
                e_din[8*(int'(off)+b) +: 8] = bus.req_wdata[8*b +: 8];
        end else begin
            e_wr = 0; e_rd = 1; lat = 3;
            v = w >> (8*off);
            m = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 1);
            v = v & m;
            if (!bus.req_unsigned && nb < 4 && v[8*nb-1]) v = v | ~m;
            e_rdata = v;
        end
        busy = 1; cyc = 0; acc_cnt++;
    endtask

    // Compare process: sample requests at posedge, check outputs after negedge.
    initial begin : compare
        forever begin
            @(posedge clk);
            if (rst) busy = 0;
            else if (busy) begin
                if (cyc >= lat) busy = 0;
            end else if (bus.req_valid) model_accept();
            @(negedge clk);
            #1;
            if (bus.resp_valid === 1'b1) pulse_cnt++;
            if (rst) begin
                busy = 0;
                chk("rst_ready", bus.req_ready, 0);
                chk("rst_resp_valid", bus.resp_valid, 0);
                chk("rst_rdata", bus.resp_rdata, 0);
                chk("rst_fault", bus.resp_fault, 0);
                chk("rst_ram_rw", bus.ram_rw, 1);
                chk("rst_ram_addr", bus.ram_addr, 0);
                chk("rst_ram_din", bus.ram_din, 0);
            end else if (busy) begin
                cyc++;
                chk("busy_ready", bus.req_ready, 0);
                chk("resp_valid", bus.resp_valid, cyc == lat);
                if (cyc == lat) begin
                    chk("resp_rdata", bus.resp_rdata, e_rdata);
                    chk("resp_fault", bus.resp_fault, e_fault);
                    last_rdata = bus.resp_rdata;
                    last_fault = bus.resp_fault;
                    last_lat   = cyc;
                    resp_cnt++;
                end
                if (e_wr && cyc == lat - 1) begin
                    chk("wr_ram_rw", bus.ram_rw, 0);
                    chk("wr_ram_addr", bus.ram_addr, e_waddr);
                    chk("wr_ram_din", bus.ram_din, e_din);
                    model_mem[e_waddr] = e_din;
                end else begin
                    chk("ram_rw_high", bus.ram_rw, 1);
                    chk("ram_din_zero", bus.ram_din, 0);
                end
                if (e_rd && cyc == 1) chk("rd_ram_addr", bus.ram_addr, e_waddr);
            end else begin
                chk("idle_ready", bus.req_ready, 1);
                chk("idle_resp_valid", bus.resp_valid, 0);
                chk("idle_ram_rw", bus.ram_rw, 1);
                chk("idle_ram_din", bus.ram_din, 0);
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
    endtask

    task automatic wait_accept(input int unsigned start);
        int unsigned n = 0;
        while (acc_cnt == start && n < 20) begin @(posedge clk); #1; n++; end
        if (acc_cnt == start) begin
            total++; bad++;
            $display("FAIL accept_timeout: got none want acceptance");
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        int unsigned start, n;
        @(negedge clk);
        start = acc_cnt;
        drive(we, sz, uns, addr, wd);
        wait_accept(start);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL resp_timeout: got busy want done");
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned w0, r0, p0, start, n;
        logic [31:0] exp_r;
        logic        exp_f;
        int unsigned exp_l;
        bus.req_valid = 1'b0;
        drive(1'b0, 2'b10, 1'b0, '0, '0);
        bus.req_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        #2 chk("lit_ready_after_rst", bus.req_ready, 1);

        // Word store / load round trip
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 18'h0, 32'd40);
        chk("lit_wst_lat", last_lat, 2);
        chk("lit_wst_writes", wr_cnt - w0, 1);
        chk("lit_mem0", mem[0], 32'd40);
        issue(1'b0, 2'b10, 1'b0, 18'h0, 32'h0);
        chk("lit_wld_lat", last_lat, 3);
        chk("lit_wld_data", last_rdata, 32'd40);

        issue(1'b1, 2'b10, 1'b0, 18'h4, 32'h1122_3344);
        issue(1'b1, 2'b10, 1'b0, 18'h8, 32'h0000_F080);

        // Byte store read-modify-write
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 18'h6, 32'h0000_00AA);
        chk("lit_bst_lat", last_lat, 4);
        chk("lit_bst_writes", wr_cnt - w0, 1);
        chk("lit_mem1", mem[1], 32'h11AA_3344);
        chk("lit_mem0_kept", mem[0], 32'd40);
        chk("lit_mem2_kept", mem[2], 32'h0000_F080);

        // Sub-word loads with extension
        issue(1'b0, 2'b00, 1'b0, 18'h8, 32'h0);
        chk("lit_lb_s", last_rdata, 32'hFFFF_FF80);
        chk("lit_lb_lat", last_lat, 3);
        issue(1'b0, 2'b00, 1'b1, 18'h8, 32'h0);
        chk("lit_lb_u", last_rdata, 32'h0000_0080);
        issue(1'b0, 2'b01, 1'b0, 18'h8, 32'h0);
        chk("lit_lh_s", last_rdata, 32'hFFFF_F080);
        issue(1'b0, 2'b01, 1'b1, 18'hA, 32'h0);
        chk("lit_lh_u_hi", last_rdata, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 18'h9, 32'h0);
        chk("lit_lb_s9", last_rdata, 32'hFFFF_FFF0);
        issue(1'b0, 2'b00, 1'b1, 18'h7, 32'h0);
        chk("lit_lb_u7", last_rdata, 32'h0000_0011);

        // Half store into upper lane
        issue(1'b1, 2'b01, 1'b0, 18'h2, 32'hDEAD_BEEF);
        chk("lit_mem0_half", mem[0], 32'hBEEF_0028);

        // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
        exp_r = 32'h0; exp_f = 1'b1; exp_l = 1;
`else
        exp_r = 32'h11AA_3344; exp_f = 1'b0; exp_l = 3;
`endif
        w0 = wr_cnt;
        issue(1'b0, 2'b10, 1'b0, 18'h5, 32'h0);
        chk("lit_mis_data", last_rdata, exp_r);
        chk("lit_mis_fault", last_fault, exp_f);
        chk("lit_mis_lat", last_lat, exp_l);
        issue(1'b0, 2'b01, 1'b0, 18'h3, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 18'h1, 32'h0000_1234);
        issue(1'b0, 2'b10, 1'b0, 18'h0, 32'h0);

        // Top word, reserved size
        issue(1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hCAFE_F00D);
        chk("lit_top_mem", mem[16'hFFFF], 32'hCAFE_F00D);
        issue(1'b0, 2'b11, 1'b0, 18'h3FFFC, 32'h0);
        chk("lit_rsvd_load", last_rdata, 32'hCAFE_F00D);
        issue(1'b0, 2'b11, 1'b0, 18'h4, 32'h0);

        // Reset during CAP of a half store abandons it
        w0 = wr_cnt; r0 = resp_cnt; p0 = pulse_cnt;
        @(negedge clk);
        start = acc_cnt;
        drive(1'b1, 2'b01, 1'b0, 18'h4, 32'h0000_5555);
        wait_accept(start);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2 chk("lit_rst_ready_1st", bus.req_ready, 1);
        repeat (3) @(negedge clk);
        chk("lit_rst_no_write", wr_cnt - w0, 0);
        chk("lit_rst_mem1", mem[1], 32'h11AA_3344);
        chk("lit_rst_no_resp", pulse_cnt - p0, 0);
        chk("lit_rst_no_model_resp", resp_cnt - r0, 0);

        // Valid held high: one response per acceptance
        r0 = resp_cnt; p0 = pulse_cnt;
        @(negedge clk);
        start = acc_cnt;
        drive(1'b0, 2'b10, 1'b0, 18'h4, 32'h0);
        n = 0;
        while (acc_cnt < start + 3 && n < 40) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        chk("lit_held_acc", acc_cnt - start, 3);
        chk("lit_held_resp", resp_cnt - r0, 3);
        chk("lit_held_pulses", pulse_cnt - p0, 3);
        chk("lit_held_data", last_rdata, 32'h11AA_3344);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
